// File: rtl/dt_skeleton.sv
// dt_skeleton -- medial-axis (skeleton) extraction over the 128x128x8 distance map.
//
// A raster scan visits every pixel. Interior pixels whose distance value is
// non-zero and not smaller than any neighbour are marked as skeleton pixels.
// Marks are packed 16 per word (leftmost column in the MSB) and written to a
// 1024x16 skeleton memory. The block also keeps a running skeleton-pixel count.
//
// Build option:
//   DT_SKE_EIGHT_NBR_EN  defined   -> 8-neighbour test (NW, N, NE, W, E, SW, S, SE)
//   DT_SKE_EIGHT_NBR_EN  undefined -> 4-neighbour test (N, W, E, S)
module dt_skeleton (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        ske_wr,
  output logic [9:0]  ske_addr,
  output logic [15:0] ske_do,
  output logic [13:0] ske_cnt
);

  // Index of the last neighbour in the read sequence.
`ifdef DT_SKE_EIGHT_NBR_EN
  localparam logic [2:0] NBR_LAST = 3'd7;
`else
  localparam logic [2:0] NBR_LAST = 3'd3;
`endif

  localparam logic [13:0] POS_LAST = 14'h3FFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CEN,
    S_CHK,
    S_NBR,
    S_PUT,
    S_FIN
  } state_t;

  state_t       state_q;
  state_t       state_d;

  logic [13:0]  pos_q;       // pixel currently being classified
  logic [7:0]   cen_q;       // centre value of the current pixel
  logic         ge_q;        // centre >= every neighbour compared so far
  logic [2:0]   idx_q;       // neighbour whose data is arriving in NBR
  logic [15:0]  sreg_q;      // packing shift register, newest pixel in bit 0
  logic [13:0]  cnt_q;       // skeleton-pixel count
  logic [13:0]  res_addr_q;  // result-memory address, loaded one cycle ahead

  logic         is_border;
  logic         ge_cmp;
  logic         put_bit;
  logic [13:0]  pos_next;

  // Address of neighbour number idx around an interior pixel. Interior pixels
  // never wrap, so plain offsets on the flat address are exact.
  function automatic logic [13:0] nbr_addr(input logic [13:0] pos,
                                           input logic [2:0]  idx);
    logic [13:0] a;
    a = pos;
`ifdef DT_SKE_EIGHT_NBR_EN
    case (idx)
      3'd0:    a = pos - 14'd129;  // NW
      3'd1:    a = pos - 14'd128;  // N
      3'd2:    a = pos - 14'd127;  // NE
      3'd3:    a = pos - 14'd1;    // W
      3'd4:    a = pos + 14'd1;    // E
      3'd5:    a = pos + 14'd127;  // SW
      3'd6:    a = pos + 14'd128;  // S
      default: a = pos + 14'd129;  // SE
    endcase
`else
    case (idx)
      3'd0:    a = pos - 14'd128;  // N
      3'd1:    a = pos - 14'd1;    // W
      3'd2:    a = pos + 14'd1;    // E
      3'd3:    a = pos + 14'd128;  // S
      default: a = pos;
    endcase
`endif
    return a;
  endfunction

  assign is_border = (pos_q[13:7] == 7'd0) || (pos_q[13:7] == 7'd127) ||
                     (pos_q[6:0]  == 7'd0) || (pos_q[6:0]  == 7'd127);
  assign ge_cmp    = ge_q & (cen_q >= res_di);
  assign pos_next  = pos_q + 14'd1;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // updates from the values present before the edge.
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the mark that is shifted in when PUT is entered.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal
    // unassigned and no latch is inferred.
    state_d = state_q;
    put_bit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CEN;
      end
      S_CEN: begin
        state_d = is_border ? S_PUT : S_CHK;
      end
      S_CHK: begin
        state_d = (res_di == 8'd0) ? S_PUT : S_NBR;
      end
      S_NBR: begin
        if (idx_q == NBR_LAST) begin
          state_d = S_PUT;
          put_bit = ge_cmp;
        end
      end
      S_PUT: begin
        state_d = (pos_q == POS_LAST) ? S_FIN : S_CEN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: pixel position, centre/compare flags, look-ahead read address,
  // packing register and skeleton counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q      <= '0;
      cen_q      <= '0;
      ge_q       <= 1'b0;
      idx_q      <= '0;
      sreg_q     <= '0;
      cnt_q      <= '0;
      res_addr_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pos_q      <= '0;
            res_addr_q <= '0;
          end
        end
        S_CEN: begin
          // Centre is being read now; queue the first neighbour for CHK.
          if (!is_border) res_addr_q <= nbr_addr(pos_q, 3'd0);
        end
        S_CHK: begin
          cen_q      <= res_di;
          ge_q       <= 1'b1;
          idx_q      <= 3'd0;
          res_addr_q <= nbr_addr(pos_q, 3'd1);
        end
        S_NBR: begin
          ge_q  <= ge_cmp;
          idx_q <= idx_q + 3'd1;
          // While neighbour k arrives, neighbour k+1 is on the bus; queue k+2.
          if (idx_q < NBR_LAST - 3'd1) res_addr_q <= nbr_addr(pos_q, idx_q + 3'd2);
        end
        S_PUT: begin
          if (pos_q != POS_LAST) begin
            pos_q      <= pos_next;
            res_addr_q <= pos_next;
          end
        end
        default: begin
        end
      endcase

      if (state_q == S_IDLE && start) begin
        sreg_q <= '0;
        cnt_q  <= '0;
      end else if (state_d == S_PUT) begin
        sreg_q <= {sreg_q[14:0], put_bit};
        cnt_q  <= cnt_q + {13'd0, put_bit};
      end
    end
  end

  // Output decode from the current state and datapath registers.
  always_comb begin
    busy     = (state_q != S_IDLE) && (state_q != S_FIN);
    done     = (state_q == S_FIN);
    res_rd   = 1'b0;
    res_addr = res_addr_q;
    ske_wr   = (state_q == S_PUT) && (pos_q[3:0] == 4'hF);
    ske_addr = ske_wr ? pos_q[13:4] : 10'd0;
    ske_do   = ske_wr ? sreg_q : 16'd0;
    ske_cnt  = cnt_q;
    case (state_q)
      S_CEN:   res_rd = !is_border;
      S_CHK:   res_rd = (res_di != 8'd0);
      S_NBR:   res_rd = (idx_q != NBR_LAST);
      default: res_rd = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_dt_skeleton.sv
// tb_dt_skeleton -- self-checking bench for dt_skeleton.
// Drives a result-memory model with one-cycle read latency, logs skeleton
// writes, and compares them with a pixel-level reference model computed
// directly from the local-maximum rule. Honours DT_SKE_EIGHT_NBR_EN.
`timescale 1ns/1ps
module tb_dt_skeleton;

`ifdef DT_SKE_EIGHT_NBR_EN
  localparam bit EIGHT     = 1'b1;
  localparam int NBR_COUNT = 8;
`else
  localparam bit EIGHT     = 1'b0;
  localparam int NBR_COUNT = 4;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, res_rd, ske_wr;
  logic [13:0] res_addr, ske_cnt;
  logic [7:0]  res_di = 8'd0;
  logic [9:0]  ske_addr;
  logic [15:0] ske_do;

  int tests = 0;
  int fails = 0;

  logic [7:0]  res_mem  [16384];
  logic [15:0] exp_word [1024];
  bit          exp_bit  [16384];
  int          exp_cnt;
  int          exp_cycles;

  logic [25:0] wr_log [$];   // {ske_addr, ske_do}
  int          stray_do     = 0;
  int          border_reads = 0;

  always #5 clk = ~clk;

  dt_skeleton dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .ske_wr   (ske_wr),
    .ske_addr (ske_addr),
    .ske_do   (ske_do),
    .ske_cnt  (ske_cnt)
  );

  function automatic bit on_border(input int p);
    int r, c;
    r = p / 128;
    c = p % 128;
    return (r == 0) || (r == 127) || (c == 0) || (c == 127);
  endfunction

  // Result memory: synchronous read, data one cycle after the address.
  always @(posedge clk) begin
    if (res_rd === 1'b1) res_di <= res_mem[res_addr];
  end

  // Observation of skeleton writes and read addresses, away from the clock edge.
  always @(negedge clk) begin
    if (ske_wr === 1'b1) wr_log.push_back({ske_addr, ske_do});
    else if (ske_do !== 16'd0) stray_do++;
    if (res_rd === 1'b1 && on_border(int'(res_addr))) border_reads++;
  end

  // Reference: a pixel is skeleton iff interior, non-zero and no neighbour is larger.
  task automatic build_model();
    exp_cnt    = 0;
    exp_cycles = 0;
    for (int w = 0; w < 1024; w++) exp_word[w] = 16'd0;
    for (int p = 0; p < 16384; p++) begin
      int r, c, v;
      bit sk;
      r  = p / 128;
      c  = p % 128;
      v  = int'(res_mem[p]);
      sk = 1'b0;
      if (on_border(p)) exp_cycles += 2;
      else if (v == 0) exp_cycles += 3;
      else begin
        exp_cycles += 3 + NBR_COUNT;
        sk = 1'b1;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && (EIGHT || dr == 0 || dc == 0))
              if (int'(res_mem[(r + dr) * 128 + c + dc]) > v) sk = 1'b0;
      end
      exp_bit[p] = sk;
      if (sk) begin
        exp_cnt++;
        exp_word[p / 16][15 - c % 16] = 1'b1;
      end
    end
  endtask

  // Pulse start and wait for done; cycles counts from the start-sampling edge.
  task automatic run_scan(output int cycles, output int busy_cycles, output bit timed_out);
    wr_log.delete();
    stray_do     = 0;
    border_reads = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    cycles      = 1;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    timed_out   = 1'b0;
    while (done !== 1'b1) begin
      if (cycles > 80000) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
      if (busy === 1'b1) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, res_rd, res_addr, ske_wr, ske_addr, ske_do, ske_cnt} !== 58'd0) begin
      fails++;
      $display("FAIL reset_values: got %h, expected all zero",
               {busy, done, res_rd, res_addr, ske_wr, ske_addr, ske_do, ske_cnt});
    end
    // start on the same edge as reset must be dropped
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_beats_start: busy got %b, expected 0", busy);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || wr_log.size() != 0) begin
      fails++;
      $display("FAIL idle_after_reset: busy got %b writes %0d, expected 0 and 0", busy, wr_log.size());
    end
  endtask

  task automatic test_skeleton_map();
    int          cycles, busy_cycles;
    bit          timed_out;
    int          hw_addr [6];
    logic [15:0] hw_val  [6];
    logic [15:0] got;

    for (int p = 0; p < 16384; p++) res_mem[p] = on_border(p) ? 8'd255 : 8'd0;
    for (int r = 4; r <= 6; r++)
      for (int c = 4; c <= 6; c++) res_mem[r * 128 + c] = 8'd1;
    res_mem[5 * 128 + 5]  = 8'd2;
    res_mem[5 * 128 + 40] = 8'd1;
    for (int r = 10; r <= 11; r++)
      for (int c = 20; c <= 21; c++) res_mem[r * 128 + c] = 8'd3;
    for (int r = 30; r <= 45; r++)
      for (int c = 30; c <= 61; c++) res_mem[r * 128 + c] = 8'($urandom_range(0, 4));
    build_model();

    run_scan(cycles, busy_cycles, timed_out);

    tests++;
    if (timed_out) begin
      fails++;
      $display("FAIL scan_timeout: done not seen after %0d cycles", cycles);
    end
    tests++;
    if (cycles != exp_cycles + 1) begin
      fails++;
      $display("FAIL done_latency: got %0d cycles, expected %0d", cycles, exp_cycles + 1);
    end
    tests++;
    if (busy_cycles != exp_cycles) begin
      fails++;
      $display("FAIL busy_cycles: got %0d, expected %0d", busy_cycles, exp_cycles);
    end
    tests++;
    if (wr_log.size() != 1024) begin
      fails++;
      $display("FAIL write_count: got %0d, expected 1024", wr_log.size());
    end
    for (int i = 0; i < wr_log.size() && i < 1024; i++) begin
      tests++;
      if (wr_log[i] !== {10'(i), exp_word[i]}) begin
        fails++;
        $display("FAIL word[%0d]: got addr %0d data %h, expected addr %0d data %h",
                 i, wr_log[i][25:16], wr_log[i][15:0], i, exp_word[i]);
      end
    end

    // Hand-derived words for the fixed patterns.
`ifdef DT_SKE_EIGHT_NBR_EN
    hw_addr = '{32, 40, 48, 42, 81, 89};
    hw_val  = '{16'h0000, 16'h0400, 16'h0000, 16'h0080, 16'h0C00, 16'h0C00};
`else
    hw_addr = '{32, 40, 48, 42, 81, 89};
    hw_val  = '{16'h0A00, 16'h0400, 16'h0A00, 16'h0080, 16'h0C00, 16'h0C00};
`endif
    for (int k = 0; k < 6; k++) begin
      got = (hw_addr[k] < wr_log.size()) ? wr_log[hw_addr[k]][15:0] : 16'hxxxx;
      tests++;
      if (got !== hw_val[k]) begin
        fails++;
        $display("FAIL pattern_word[%0d]: got %h, expected %h", hw_addr[k], got, hw_val[k]);
      end
    end

    tests++;
    if (ske_cnt !== 14'(exp_cnt)) begin
      fails++;
      $display("FAIL ske_cnt: got %0d, expected %0d", ske_cnt, exp_cnt);
    end
    tests++;
    if (border_reads != 0) begin
      fails++;
      $display("FAIL border_reads: got %0d, expected 0", border_reads);
    end
    tests++;
    if (stray_do != 0) begin
      fails++;
      $display("FAIL ske_do_idle: got %0d nonzero cycles, expected 0", stray_do);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: done %b busy %b, expected 0 0", done, busy);
    end
    repeat (5) @(negedge clk);
    tests++;
    if (ske_cnt !== 14'(exp_cnt)) begin
      fails++;
      $display("FAIL ske_cnt_hold: got %0d, expected %0d", ske_cnt, exp_cnt);
    end
  endtask

  task automatic test_restart_and_reset();
    int waited, bad, exp_part;

    for (int p = 0; p < 16384; p++) res_mem[p] = 8'd0;
    res_mem[3 * 128 + 3]   = 8'd1;
    res_mem[20 * 128 + 50] = 8'd6;
    build_model();
    exp_part = 0;
    for (int p = 0; p < 5000; p++) exp_part += int'(exp_bit[p]);

    wr_log.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    start = 1'b1;            // must be ignored while busy
    @(negedge clk);
    start = 1'b0;

    waited = 0;
    while (!(res_rd === 1'b1 && res_addr === 14'd5000) && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (waited >= 20000) begin
      fails++;
      $display("FAIL reach_pixel_5000: got timeout after %0d cycles, expected read of 5000", waited);
    end
    tests++;
    if (ske_cnt !== 14'(exp_part)) begin
      fails++;
      $display("FAIL partial_cnt: got %0d, expected %0d", ske_cnt, exp_part);
    end
    tests++;
    if (wr_log.size() != 5000 / 16) begin
      fails++;
      $display("FAIL partial_writes: got %0d, expected %0d", wr_log.size(), 5000 / 16);
    end
    bad = 0;
    for (int i = 0; i < wr_log.size() && i < 1024; i++)
      if (wr_log[i] !== {10'(i), exp_word[i]}) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL partial_sequence: got %0d wrong entries, expected 0", bad);
    end

    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({busy, ske_wr, ske_cnt} !== 16'd0) begin
      fails++;
      $display("FAIL midscan_reset: busy %b ske_wr %b ske_cnt %0d, expected 0 0 0",
               busy, ske_wr, ske_cnt);
    end
    tests++;
    if ({done, res_rd, res_addr, ske_addr, ske_do} !== 42'd0) begin
      fails++;
      $display("FAIL midscan_reset_outputs: got %h, expected 0",
               {done, res_rd, res_addr, ske_addr, ske_do});
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_midscan_reset: busy got %b, expected 0", busy);
    end

    wr_log.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (wr_log.size() < 4 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    tests++;
    if (wr_log.size() < 4) begin
      fails++;
      $display("FAIL rescan_writes: got %0d, expected at least 4", wr_log.size());
    end
    bad = 0;
    for (int i = 0; i < 4 && i < wr_log.size(); i++)
      if (wr_log[i] !== {10'(i), 16'h0000}) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rescan_from_zero: got %0d wrong entries, expected 0", bad);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_skeleton_map();
    test_restart_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
